bmc_tx: RTL

//  USB-PD BMC transmitter: drives cc_dout/cc_io_ctrl into cc_line. Takes 5-bit
//  pre-encoded 4b5b symbols (SOP, data, CRC, EOP) from the protocol layer.

---
 rtl/bmc_tx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/bmc_tx.sv
// USB-PD BMC transmitter: preamble, then 4b5b symbols LSB first, then a tail edge
// and a low hold before releasing the CC line.
module bmc_tx #(
    parameter int unsigned system_khz    = 200000,
    parameter int unsigned bit_khz       = 300,
    parameter int unsigned preamble_bits = 64,
    parameter int unsigned hold_ns       = 1000
) (
    input  logic       clock,
    input  logic       nrst,
    input  logic       tx_start,
    input  logic [4:0] tx_sym,
    input  logic       tx_sym_valid,
    input  logic       tx_sym_last,
    output logic       tx_sym_ready,
    input  logic       cc_lock,
    output logic       cc_dout,
    output logic       cc_io_ctrl,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned Half    = system_khz / (2 * bit_khz);
    localparam int unsigned HoldCyc = (system_khz * hold_ns) / 1000000;
    localparam int unsigned CntW    = (Half > 1) ? $clog2(Half) : 1;
    localparam int unsigned HoldW   = (HoldCyc > 1) ? $clog2(HoldCyc) : 1;
    localparam int unsigned PreW    = (preamble_bits > 1) ? $clog2(preamble_bits) : 1;

    localparam logic [CntW-1:0]  HalfMax = CntW'(Half - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCyc - 1);
    localparam logic [PreW-1:0]  PreMax  = PreW'(preamble_bits - 1);

    typedef enum logic [2:0] {StIdle, StPre, StData, StTail, StHold} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             half_q, half_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [2:0]       bit_q, bit_d;
    logic [4:0]       shift_q, shift_d;
    logic             last_q, last_d;
    logic [4:0]       buf_q, buf_d;
    logic             buf_last_q, buf_last_d;
    logic             buf_valid_q, buf_valid_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             abort_q, abort_d;
    logic             dout_q, dout_d;
    logic             io_q, io_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic cur_bit;
    logic boundary;

    assign tx_sym_ready = !buf_valid_q && ((state_q == StPre) || (state_q == StData));
    assign tx_busy      = (state_q != StIdle);
    assign cc_dout      = dout_q;
    assign cc_io_ctrl   = io_q;
    assign tx_done      = done_q;
    assign tx_err       = err_q;

    // Preamble alternates 0,1,... so the bit value is the LSB of its index.
    assign cur_bit  = (state_q == StPre) ? pre_q[0] : shift_q[0];
    assign boundary = ((state_q == StPre) && (pre_q == PreMax)) ||
                      ((state_q == StData) && (bit_q == 3'd4));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        half_d      = half_q;
        pre_d       = pre_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        last_d      = last_q;
        buf_d       = buf_q;
        buf_last_d  = buf_last_q;
        buf_valid_d = buf_valid_q;
        hold_d      = hold_q;
        abort_d     = abort_q;
        dout_d      = dout_q;
        io_d        = io_q;
        err_d       = 1'b0;
        done_d      = 1'b0;

        if (tx_sym_valid && tx_sym_ready) begin
            buf_d       = tx_sym;
            buf_last_d  = tx_sym_last;
            buf_valid_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (tx_start) begin
                    if (cc_lock) begin
                        state_d = StPre;
                        io_d    = 1'b1;
                        dout_d  = 1'b1;
                        cnt_d   = '0;
                        half_d  = 1'b0;
                        pre_d   = '0;
                        bit_d   = '0;
                        last_d  = 1'b0;
                        abort_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StPre, StData: begin
                if (cnt_q == HalfMax) begin
                    cnt_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        if (cur_bit) dout_d = ~dout_q;
                    end else begin
                        half_d = 1'b0;
                        if (!boundary) begin
                            if (state_q == StPre) begin
                                pre_d = pre_q + 1'b1;
                            end else begin
                                shift_d = {1'b0, shift_q[4:1]};
                                bit_d   = bit_q + 1'b1;
                            end
                            dout_d = ~dout_q;
                        end else if ((state_q == StData) && last_q) begin
                            state_d = StTail;
                            dout_d  = 1'b0;
                        end else if (buf_valid_q) begin
                            state_d     = StData;
                            shift_d     = buf_q;
                            last_d      = buf_last_q;
                            buf_valid_d = 1'b0;
                            bit_d       = '0;
                            dout_d      = ~dout_q;
                        end else begin
                            // Underrun: nothing to send at a symbol boundary.
                            state_d = StTail;
                            dout_d  = 1'b0;
                            err_d   = 1'b1;
                            abort_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTail: begin
                state_d = StHold;
                hold_d  = '0;
            end
            StHold: begin
                if (hold_q == HoldMax) begin
                    state_d = StIdle;
                    io_d    = 1'b0;
                    done_d  = !abort_q;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            pre_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            buf_q       <= '0;
            buf_last_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            hold_q      <= '0;
            abort_q     <= 1'b0;
            dout_q      <= 1'b0;
            io_q        <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pre_q       <= pre_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            buf_q       <= buf_d;
            buf_last_q  <= buf_last_d;
            buf_valid_q <= buf_valid_d;
            hold_q      <= hold_d;
            abort_q     <= abort_d;
            dout_q      <= dout_d;
            io_q        <= io_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

endmodule
